// File: rtl/scan_sequencer_pkg.sv
// Shared constants and state encoding for the search-window scan sequencer.
// Frame geometry is fixed at 64x64; index and score widths are set here.
package scan_sequencer_pkg;

   localparam int FRAME_W_LOG2 = 6;
   localparam int FRAME_W      = 1 << FRAME_W_LOG2;
   localparam int FRAME_H      = 64;
   localparam int IDX_W        = 16;
   localparam int SCORE_W      = 32;

   localparam logic [SCORE_W-1:0] SCORE_MAX   = {SCORE_W{1'b1}};
   localparam logic [IDX_W:0]     FRAME_W_LIM = (IDX_W+1)'(FRAME_W);
   localparam logic [IDX_W:0]     FRAME_H_LIM = (IDX_W+1)'(FRAME_H);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CHECK  = 3'd1,
      ST_ISSUE  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_FINISH = 3'd4
   } state_e;

endpackage

// File: rtl/scan_addr_gen.sv
// Column/row walker over the latched window; forms the linear frame index
// of the current element and flags the last element of the window.
module scan_addr_gen
   import scan_sequencer_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [IDX_W-1:0] win_x0_i,
   input  logic [IDX_W-1:0] win_y0_i,
   input  logic [IDX_W-1:0] win_w_i,
   input  logic [IDX_W-1:0] win_h_i,
   output logic [IDX_W-1:0] index_o,
   output logic             last_o
);

   logic [IDX_W-1:0] col_q, col_d;
   logic [IDX_W-1:0] row_q, row_d;
   logic [IDX_W-1:0] col_abs, row_abs;
   logic             col_wrap;

   assign col_wrap = (col_q == (win_w_i - IDX_W'(1)));
   assign last_o   = col_wrap && (row_q == (win_h_i - IDX_W'(1)));

   assign col_abs = win_x0_i + col_q;
   assign row_abs = win_y0_i + row_q;
   assign index_o = (row_abs << FRAME_W_LOG2) + col_abs;

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear_i) begin
         col_d = '0;
         row_d = '0;
      end else if (advance_i) begin
         if (col_wrap) begin
            col_d = '0;
            row_d = row_q + IDX_W'(1);
         end else begin
            col_d = col_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/scan_sequencer.sv
// Walks a search window one index at a time, collects one score per index
// and reports the minimum score and where it occurred.
//
// Handshake: Index is offered while IdxValid=1 and held stable until a cycle
// with IdxValid&IdxReady; exactly one index is outstanding, and its score is
// taken from the first ScoreValid seen in WAIT (ScoreValid elsewhere ignored).
module scan_sequencer
   import scan_sequencer_pkg::*;
(
   input  logic               Clk,
   input  logic               Rst,
   input  logic               Start,
   input  logic [IDX_W-1:0]   WinX0,
   input  logic [IDX_W-1:0]   WinY0,
   input  logic [IDX_W-1:0]   WinW,
   input  logic [IDX_W-1:0]   WinH,
   output logic               IdxValid,
   output logic [IDX_W-1:0]   Index,
   input  logic               IdxReady,
   input  logic               ScoreValid,
   input  logic [SCORE_W-1:0] Score,
   output logic               Busy,
   output logic               Done,
   output logic               Err,
   output logic [IDX_W-1:0]   BestIndex,
   output logic [SCORE_W-1:0] BestScore,
   output logic               CoordSignal,
   output logic [2:0]         DbgState
);

   state_e             state_q;
   logic [IDX_W-1:0]   win_x0_q, win_y0_q, win_w_q, win_h_q;
   logic               idx_valid_q, busy_q, done_q, err_q;
   logic [IDX_W-1:0]   best_idx_q;
   logic [SCORE_W-1:0] best_score_q;

   logic               addr_clear, addr_advance, addr_last;
   logic [IDX_W-1:0]   addr_index;
   logic [IDX_W:0]     x_end, y_end;
   logic               window_bad;

   // Extra bit on the sums so a huge origin plus width cannot wrap below 64.
   assign x_end      = {1'b0, win_x0_q} + {1'b0, win_w_q};
   assign y_end      = {1'b0, win_y0_q} + {1'b0, win_h_q};
   assign window_bad = (win_w_q == '0) || (win_h_q == '0) ||
                       (x_end > FRAME_W_LIM) || (y_end > FRAME_H_LIM);

   assign addr_clear   = (state_q == ST_IDLE) && Start;
   assign addr_advance = (state_q == ST_WAIT) && ScoreValid;

   scan_addr_gen u_addr_gen (
      .clk_i     (Clk),
      .rst_i     (Rst),
      .clear_i   (addr_clear),
      .advance_i (addr_advance),
      .win_x0_i  (win_x0_q),
      .win_y0_i  (win_y0_q),
      .win_w_i   (win_w_q),
      .win_h_i   (win_h_q),
      .index_o   (addr_index),
      .last_o    (addr_last)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= ST_IDLE;
         win_x0_q     <= '0;
         win_y0_q     <= '0;
         win_w_q      <= '0;
         win_h_q      <= '0;
         idx_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         best_idx_q   <= '0;
         best_score_q <= SCORE_MAX;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  win_x0_q     <= WinX0;
                  win_y0_q     <= WinY0;
                  win_w_q      <= WinW;
                  win_h_q      <= WinH;
                  err_q        <= 1'b0;
                  best_idx_q   <= '0;
                  best_score_q <= SCORE_MAX;
                  busy_q       <= 1'b1;
                  state_q      <= ST_CHECK;
               end
            end
            ST_CHECK: begin
               if (window_bad) begin
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
                  state_q <= ST_FINISH;
               end else begin
                  idx_valid_q <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (idx_valid_q && IdxReady) begin
                  idx_valid_q <= 1'b0;
                  state_q     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (ScoreValid) begin
                  // Strict compare: a tie keeps the earlier index.
                  if (Score < best_score_q) begin
                     best_score_q <= Score;
                     best_idx_q   <= addr_index;
                  end
                  if (addr_last) begin
                     done_q  <= 1'b1;
                     state_q <= ST_FINISH;
                  end else begin
                     idx_valid_q <= 1'b1;
                     state_q     <= ST_ISSUE;
                  end
               end
            end
            ST_FINISH: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign IdxValid    = idx_valid_q;
   assign Index       = addr_index;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Err         = err_q;
   assign BestIndex   = best_idx_q;
   assign BestScore   = best_score_q;
   assign CoordSignal = done_q;
   assign DbgState    = state_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Bench for scan_sequencer: expected indices are queued when a scan is
// started and popped as the DUT offers them; the minimum is modelled here.
module tb_scan_sequencer;

   logic        Clk = 1'b0;
   logic        Rst = 1'b1;
   logic        Start = 1'b0;
   logic [15:0] WinX0 = '0, WinY0 = '0, WinW = '0, WinH = '0;
   logic        IdxValid;
   logic [15:0] Index;
   logic        IdxReady = 1'b0;
   logic        ScoreValid = 1'b0;
   logic [31:0] Score = '0;
   logic        Busy, Done, Err, CoordSignal;
   logic [15:0] BestIndex;
   logic [31:0] BestScore;
   logic [2:0]  DbgState;

   logic [15:0] exp_q[$];
   logic [31:0] score_q[$];
   int          pass_cnt = 0;
   int          total_cnt = 0;

   always #5 Clk = ~Clk;

   scan_sequencer dut (
      .Clk(Clk), .Rst(Rst), .Start(Start),
      .WinX0(WinX0), .WinY0(WinY0), .WinW(WinW), .WinH(WinH),
      .IdxValid(IdxValid), .Index(Index), .IdxReady(IdxReady),
      .ScoreValid(ScoreValid), .Score(Score),
      .Busy(Busy), .Done(Done), .Err(Err),
      .BestIndex(BestIndex), .BestScore(BestScore),
      .CoordSignal(CoordSignal), .DbgState(DbgState)
   );

   task automatic check_reset_values(input string tag);
      total_cnt++;
      if ({IdxValid, Busy, Done, Err, CoordSignal} !== 5'b0 || Index !== 16'd0 ||
          BestIndex !== 16'd0 || BestScore !== 32'hFFFF_FFFF || DbgState !== 3'd0)
         $display("FAIL %s: got v=%b i=%0d busy=%b done=%b err=%b bi=%0d bs=%h st=%0d, want all reset values",
                  tag, IdxValid, Index, Busy, Done, Err, BestIndex, BestScore, DbgState);
      else pass_cnt++;
   endtask

   // Runs one scan. stall_n: cycles IdxReady is held low on the 2nd index;
   // poke_cyc: cycle at which a Start with another window is pulsed;
   // abort_at: accepted-index count at which Rst is asserted in WAIT.
   task automatic run_scan(input int x0, input int y0, input int w, input int h,
                           input bit exp_err, input int stall_n,
                           input int poke_cyc, input int abort_at);
      logic [31:0] e_best;
      logic [15:0] e_best_idx, held_idx, exp_idx;
      int cyc, accepted, stall_left;
      bit done_seen, pend_score;
      exp_q.delete();
      e_best = 32'hFFFF_FFFF;
      e_best_idx = 16'd0;
      if (!exp_err) begin
         for (int i = 0; i < w * h; i++) begin
            exp_idx = 16'(((y0 + i / w) << 6) + x0 + i % w);
            exp_q.push_back(exp_idx);
            if (score_q[i] < e_best) begin
               e_best = score_q[i];
               e_best_idx = exp_idx;
            end
         end
      end
      @(negedge Clk);
      Start = 1'b1;
      WinX0 = 16'(x0); WinY0 = 16'(y0); WinW = 16'(w); WinH = 16'(h);
      @(negedge Clk);
      Start = 1'b0;
      cyc = 1; accepted = 0; stall_left = stall_n;
      done_seen = 1'b0; pend_score = 1'b0; held_idx = '0;
      for (int t = 0; t < 300; t++) begin
         ScoreValid = 1'b0;
         IdxReady = 1'b0;
         Start = 1'b0;
         total_cnt++;
         if (CoordSignal !== Done) $display("FAIL coord_eq_done: coord=%b done=%b", CoordSignal, Done);
         else pass_cnt++;
         total_cnt++;
         if (Busy !== 1'b1) $display("FAIL busy_during_scan: got %b want 1 (cycle %0d)", Busy, cyc);
         else pass_cnt++;
         if (Done === 1'b1) begin
            done_seen = 1'b1;
            if (exp_err) begin
               total_cnt++;
               if (cyc !== 2) $display("FAIL err_done_latency: got cycle %0d want 2", cyc);
               else pass_cnt++;
            end
            break;
         end
         if (exp_err) begin
            total_cnt++;
            if (IdxValid !== 1'b0) $display("FAIL no_index_on_err: IdxValid=%b want 0", IdxValid);
            else pass_cnt++;
         end
         if (cyc == poke_cyc) begin
            Start = 1'b1;
            WinX0 = 16'd0; WinY0 = 16'd0; WinW = 16'd1; WinH = 16'd1;
         end
         if (pend_score) begin
            pend_score = 1'b0;
            if (accepted == abort_at) begin
               Rst = 1'b1;
               @(negedge Clk);
               Rst = 1'b0;
               check_reset_values("reset_in_wait");
               @(negedge Clk);
               total_cnt++;
               if (Done !== 1'b0 || Busy !== 1'b0) $display("FAIL no_done_after_abort: done=%b busy=%b want 0 0", Done, Busy);
               else pass_cnt++;
               exp_q.delete();
               return;
            end
            ScoreValid = 1'b1;
            Score = score_q[accepted-1];
         end else if (accepted == 1 && stall_left > 0) begin
            if (stall_left == stall_n) begin
               if (IdxValid === 1'b1) begin
                  held_idx = Index;
                  stall_left--;
                  ScoreValid = 1'b1;
                  Score = 32'd0;
               end
            end else begin
               total_cnt++;
               if (IdxValid !== 1'b1 || Index !== held_idx)
                  $display("FAIL stall_hold: valid=%b idx=%0d want 1 %0d", IdxValid, Index, held_idx);
               else pass_cnt++;
               stall_left--;
               ScoreValid = 1'b1;
               Score = 32'd0;
            end
         end else if (IdxValid === 1'b1) begin
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL extra_index: got %0d want none", Index);
            else begin
               exp_idx = exp_q.pop_front();
               if (Index !== exp_idx) $display("FAIL index_seq: got %0d want %0d", Index, exp_idx);
               else pass_cnt++;
            end
            IdxReady = 1'b1;
            accepted++;
            pend_score = 1'b1;
         end
         @(negedge Clk);
         cyc++;
      end
      ScoreValid = 1'b0;
      IdxReady = 1'b0;
      Start = 1'b0;
      total_cnt++;
      if (!done_seen) $display("FAIL done_timeout: no Done within budget");
      else pass_cnt++;
      total_cnt++;
      if (exp_q.size() != 0) $display("FAIL missing_index: %0d left want 0", exp_q.size());
      else pass_cnt++;
      total_cnt++;
      if (Err !== exp_err) $display("FAIL err_flag: got %b want %b", Err, exp_err);
      else pass_cnt++;
      total_cnt++;
      if (BestIndex !== e_best_idx) $display("FAIL best_index: got %0d want %0d", BestIndex, e_best_idx);
      else pass_cnt++;
      total_cnt++;
      if (BestScore !== e_best) $display("FAIL best_score: got %h want %h", BestScore, e_best);
      else pass_cnt++;
      @(negedge Clk);
      total_cnt++;
      if (Done !== 1'b0 || CoordSignal !== 1'b0 || Busy !== 1'b0)
         $display("FAIL done_one_pulse: done=%b coord=%b busy=%b want 0 0 0", Done, CoordSignal, Busy);
      else pass_cnt++;
      total_cnt++;
      if (Err !== exp_err || BestIndex !== e_best_idx) $display("FAIL result_hold: err=%b bi=%0d want %b %0d", Err, BestIndex, exp_err, e_best_idx);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      check_reset_values("reset_state");
   endtask

   task automatic test_basic();
      score_q = '{32'd9, 32'd4, 32'd4, 32'd7};
      run_scan(3, 5, 2, 2, 1'b0, 0, -1, -1);
   endtask

   task automatic test_reject();
      score_q.delete();
      run_scan(3, 5, 0, 2, 1'b1, 0, -1, -1);
      run_scan(62, 0, 4, 1, 1'b1, 0, -1, -1);
      run_scan(0, 63, 2, 2, 1'b1, 0, -1, -1);
      score_q = '{32'd50, 32'd20, 32'd30, 32'd10};
      run_scan(60, 0, 4, 1, 1'b0, 0, -1, -1);
   endtask

   task automatic test_stall();
      score_q = '{32'd9, 32'd4, 32'd4, 32'd7};
      run_scan(3, 5, 2, 2, 1'b0, 5, -1, -1);
   endtask

   task automatic test_abort();
      score_q = '{32'd9, 32'd4, 32'd4, 32'd7};
      run_scan(3, 5, 2, 2, 1'b0, 0, -1, 3);
      score_q = '{32'd6, 32'd3, 32'd8, 32'd1};
      run_scan(3, 5, 2, 2, 1'b0, 0, -1, -1);
   endtask

   task automatic test_start_while_busy();
      score_q = '{32'd5, 32'd8, 32'd2, 32'd2};
      run_scan(3, 5, 2, 2, 1'b0, 0, 4, -1);
      score_q = '{32'd0};
      run_scan(10, 7, 1, 1, 1'b0, 0, -1, -1);
   endtask

   task automatic test_random();
      int w, h;
      for (int n = 0; n < 4; n++) begin
         w = $urandom_range(1, 4);
         h = $urandom_range(1, 3);
         score_q.delete();
         for (int i = 0; i < w * h; i++) score_q.push_back(32'($urandom_range(0, 15)));
         run_scan($urandom_range(0, 64 - w), $urandom_range(0, 64 - h), w, h, 1'b0, 0, -1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_reject();
      test_stall();
      test_abort();
      test_start_while_busy();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Sequences a rectangular search window over the 64-column frame. Emits one linear pixel index per step over a valid/ready handshake to the scoring datapath and collects one score per index. Tracks the minimum score and its index. On completion, pulses the coordinate-conversion enable so the winning index is converted to X/Y.

Parameters:
FRAME_W_LOG2, 6, log2 of frame width in pixels (64 columns)
IDX_W, 16, linear index width
SCORE_W, 32, score width

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  synchronous, active-high reset
Start  in  1  begin scan; sampled only in IDLE
WinX0  in  IDX_W  window left column
WinY0  in  IDX_W  window top row
WinW  in  IDX_W  window width in pixels
WinH  in  IDX_W  window height in pixels
IdxValid  out  1  Index is valid
Index  out  IDX_W  linear index = (row << FRAME_W_LOG2) + col
IdxReady  in  1  datapath accepts Index
ScoreValid  in  1  Score is valid (one per accepted index)
Score  in  SCORE_W  score for the last accepted index
Busy  out  1  high from the cycle after Start until DONE is exited
Done  out  1  one-cycle completion pulse
Err  out  1  window rejected; valid with Done, held until next Start
BestIndex  out  IDX_W  index of the minimum score
BestScore  out  SCORE_W  minimum score
CoordSignal  out  1  enable for the coordinate conversion; equals Done

Behaviour:
- Reset values: IdxValid=0, Index=0, Busy=0, Done=0, Err=0, BestIndex=0, BestScore=all-ones, CoordSignal=0, state=IDLE, col=row=0.
- Rst takes effect on the next edge from any state. A scan in progress is abandoned; no Done is produced.
- States: IDLE, CHECK, ISSUE, WAIT, FINISH.
- IDLE, Start=1: latch window registers, clear Err, BestScore<=all-ones, BestIndex<=0, col=row=0; go to CHECK (cycle 1). Busy=1 from cycle 1.
- CHECK: go to FINISH with Err=1 if WinW==0, WinH==0, WinX0+WinW>64, or WinY0+WinH>64. Otherwise go to ISSUE.
- ISSUE: IdxValid=1, Index=((WinY0+row)<<6)+(WinX0+col), truncated to IDX_W. Index is held stable while IdxReady=0. On IdxValid&IdxReady, go to WAIT with IdxValid=0 the next cycle.
- WAIT: sample Score on ScoreValid.
  - If Score < BestScore (strict), update BestScore and BestIndex. Ties keep the earlier index.
  - Then advance: col+1; at col==WinW-1, wrap to col=0 and row+1.
  - If the last element is done (col==WinW-1 and row==WinH-1), go to FINISH; else go to ISSUE.
- ScoreValid outside WAIT is ignored. Exactly one index is outstanding at a time.
- Throughput: minimum 2 cycles per index (ISSUE accept cycle, then ScoreValid in the following WAIT cycle).
- FINISH: Done=1 and CoordSignal=1 for exactly one cycle; Busy=0 from the next cycle; return to IDLE.
- Best* and Err hold until the next accepted Start. Start outside IDLE is ignored.
- Arithmetic: row/col counters are IDX_W wide. Bound checks use IDX_W+1-bit sums so overflow cannot alias.
- Rejected window: Done asserted 2 cycles after Start (cycle 0 Start, cycle 1 CHECK, cycle 2 FINISH). BestScore=all-ones, BestIndex=0.

Decomposition:
- Shared package: FRAME_W_LOG2, frame height constant 64, state encoding (3-bit enum), SCORE_MAX all-ones constant.
- One natural sub-module: scan_addr_gen (col/row counters, wrap and last detection, Index formation), instantiated by the FSM.
- Min-tracking stays inline.

Test Plan:
- Window X0=3,Y0=5,W=2,H=2, IdxReady=1, scores returned 1 cycle after accept: 9,4,4,7 -> Index sequence 323,324,387,388; Done one pulse; BestIndex=324, BestScore=4 (tie keeps first); CoordSignal coincident with Done.
- WinW=0 -> Done and Err at cycle 2 after Start; no IdxValid ever; BestScore=0xFFFFFFFF, BestIndex=0.
- X0=62,W=4,Y0=0,H=1 -> Err=1, Done at cycle 2, no index issued. Repeat with X0=60,W=4 -> accepted, indices 60..63.
- Same 2x2 window with IdxReady held low 5 cycles on the 2nd index -> Index stays 324 and IdxValid stays 1 throughout; spurious ScoreValid during ISSUE is ignored; final result unchanged.
- Rst asserted while in WAIT after 2 of 4 indices -> next cycle all outputs at reset values, no Done. A fresh Start then runs the full scan correctly.
- Start pulsed while Busy with a different window -> ignored; results match the original window. A 1x1 window with score 0 -> BestScore=0, BestIndex=(Y0<<6)+X0.
